// File: rtl/daq_pg_pkg.sv
// Shared encodings and LFSR constants for the DAQ pattern generator.
package daq_pg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } pg_state_e;

    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_TAG  = 2'd1,
        MODE_WALK = 2'd2,
        MODE_PRBS = 2'd3
    } pg_mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting register land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/pg_lfsr16.sv
// 16-bit Fibonacci LFSR with step enable and reseed; exposes the low OUT_W bits.
module pg_lfsr16
    import daq_pg_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             reseed_i,
    output logic [OUT_W-1:0] data_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed_i)
            lfsr_d = LFSR_SEED;
        else if (en_i)
            lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= lfsr_d;
    end

    assign data_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/daq_pattern_gen.sv
// Burst test-pattern source for a DAQ readout FIFO: IDLE/RUN/GAP sequencer,
// strip/chan/samp word counters and four selectable data patterns.
module daq_pattern_gen
    import daq_pg_pkg::*;
#(
    parameter int DWIDTH  = 12,
    parameter int NCHAN   = 6,
    parameter int NSTRIP  = 16,
    parameter int GAP_CYC = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic              CONT,
    input  logic [1:0]        MODE,
    input  logic [6:0]        NSAMP,
    input  logic              FULL,
    output logic [DWIDTH-1:0] WDATA,
    output logic              WREN,
    output logic              BUSY,
    output logic              DONE,
    output logic [15:0]       BURST_CNT,
    output logic [7:0]        LOST_CNT
);

    localparam logic [DWIDTH-1:0] WALK_ONE = DWIDTH'(1);

    pg_state_e         state_q, state_d;
    pg_mode_e          mode_q, mode_d;
    logic [3:0]        strip_q, strip_d;
    logic [2:0]        chan_q, chan_d;
    logic [6:0]        samp_q, samp_d;
    logic [6:0]        nsamp_q, nsamp_d;
    logic [DWIDTH-1:0] widx_q, widx_d;
    logic [3:0]        woff_q, woff_d;
    logic [7:0]        gap_q, gap_d;
    logic              done_q, done_d;
    logic [15:0]       burst_q, burst_d;
    logic [7:0]        lost_q, lost_d;

    logic              wr_en, last_word, burst_end, gap_end;
    logic              start_ok, restart_ok, begin_burst;
    logic [11:0]       tag;
    logic [DWIDTH-1:0] tag_w, walk, prbs, pattern;

    assign wr_en      = (state_q == ST_RUN) && !FULL && !ABORT;
    assign last_word  = (strip_q == 4'(NSTRIP - 1)) && (chan_q == 3'(NCHAN - 1))
                        && (samp_q == nsamp_q - 7'd1);
    assign burst_end  = wr_en && last_word;
    assign gap_end    = (gap_q == 8'(GAP_CYC - 1));
    assign start_ok   = START && (state_q == ST_IDLE) && (NSAMP != 7'd0);
    assign restart_ok = CONT && (NSAMP != 7'd0);
    // Any entry into RUN, including a back-to-back restart, starts a fresh burst.
    assign begin_burst = (state_d == ST_RUN) && ((state_q != ST_RUN) || burst_end);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_INC;
            strip_q <= '0;
            chan_q  <= '0;
            samp_q  <= '0;
            nsamp_q <= '0;
            widx_q  <= '0;
            woff_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            burst_q <= '0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            strip_q <= strip_d;
            chan_q  <= chan_d;
            samp_q  <= samp_d;
            nsamp_q <= nsamp_d;
            widx_q  <= widx_d;
            woff_q  <= woff_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            burst_q <= burst_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_ok) state_d = ST_RUN;
                ST_RUN: begin
                    if (burst_end) begin
                        if (GAP_CYC > 0)
                            state_d = ST_GAP;
                        else
                            state_d = restart_ok ? ST_RUN : ST_IDLE;
                    end
                end
                ST_GAP:  if (gap_end) state_d = restart_ok ? ST_RUN : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mode_d  = mode_q;
        nsamp_d = nsamp_q;
        strip_d = strip_q;
        chan_d  = chan_q;
        samp_d  = samp_q;
        widx_d  = widx_q;
        woff_d  = woff_q;
        gap_d   = '0;
        if (state_q == ST_GAP && !gap_end && !ABORT)
            gap_d = gap_q + 8'd1;

        if (ABORT || begin_burst) begin
            strip_d = '0;
            chan_d  = '0;
            samp_d  = '0;
            widx_d  = '0;
            woff_d  = '0;
        end else if (wr_en) begin
            widx_d = widx_q + DWIDTH'(1);
            woff_d = (woff_q == 4'(DWIDTH - 1)) ? 4'd0 : woff_q + 4'd1;
            if (strip_q == 4'(NSTRIP - 1)) begin
                strip_d = '0;
                if (chan_q == 3'(NCHAN - 1)) begin
                    chan_d = '0;
                    samp_d = samp_q + 7'd1;
                end else begin
                    chan_d = chan_q + 3'd1;
                end
            end else begin
                strip_d = strip_q + 4'd1;
            end
        end

        if (begin_burst) begin
            nsamp_d = NSAMP;
            mode_d  = pg_mode_e'(MODE);
        end

        done_d  = burst_end;
        burst_d = burst_end ? burst_q + 16'd1 : burst_q;
        lost_d  = lost_q;
        if (START && !ABORT && !start_ok && lost_q != 8'hFF)
            lost_d = lost_q + 8'd1;
    end

    assign tag  = {chan_q, samp_q[4:0], strip_q};
    assign walk = WALK_ONE << woff_q;

    if (DWIDTH >= 12) begin : g_tag_pad
        assign tag_w = DWIDTH'(tag);
    end else begin : g_tag_trunc
        assign tag_w = tag[DWIDTH-1:0];
    end

    pg_lfsr16 #(
        .OUT_W (DWIDTH)
    ) u_lfsr (
        .clk_i    (CLK),
        .rst_i    (RST),
        .en_i     (wr_en),
        .reseed_i (ABORT || begin_burst),
        .data_o   (prbs)
    );

    // Handshake outputs are masked combinationally so they drop in the same
    // cycle ABORT or RST rises.
    always_comb begin
        case (mode_q)
            MODE_INC:  pattern = widx_q;
            MODE_TAG:  pattern = tag_w;
            MODE_WALK: pattern = walk;
            MODE_PRBS: pattern = prbs;
            default:   pattern = '0;
        endcase
        WDATA     = (state_q == ST_RUN) ? pattern : '0;
        WREN      = wr_en && !RST;
        BUSY      = (state_q != ST_IDLE) && !ABORT && !RST;
        DONE      = done_q && !ABORT && !RST;
        BURST_CNT = burst_q;
        LOST_CNT  = lost_q;
    end

endmodule

// File: tb/tb_daq_pattern_gen.sv
// Self-checking bench for daq_pattern_gen: cycle table, directed corner cases
// and randomized bursts compared against an arithmetic pattern model.
module tb_daq_pattern_gen;

    localparam int DWIDTH  = 12;
    localparam int NCHAN   = 6;
    localparam int NSTRIP  = 16;
    localparam int GAP_CYC = 4;
    localparam int WPS     = NCHAN * NSTRIP;

    logic        clk = 1'b0;
    logic        RST = 1'b1, START = 1'b0, ABORT = 1'b0, CONT = 1'b0, FULL = 1'b0;
    logic [1:0]  MODE = 2'd0;
    logic [6:0]  NSAMP = 7'd0;
    logic [11:0] WDATA;
    logic        WREN, BUSY, DONE;
    logic [15:0] BURST_CNT;
    logic [7:0]  LOST_CNT;

    int n_checks = 0, n_err = 0, exp_bursts = 0, exp_lost = 0;
    logic [15:0] prbs [0:1023];

    always #5 clk = ~clk;

    daq_pattern_gen #(
        .DWIDTH(DWIDTH), .NCHAN(NCHAN), .NSTRIP(NSTRIP), .GAP_CYC(GAP_CYC)
    ) dut (
        .CLK(clk), .RST(RST), .START(START), .ABORT(ABORT), .CONT(CONT),
        .MODE(MODE), .NSAMP(NSAMP), .FULL(FULL), .WDATA(WDATA), .WREN(WREN),
        .BUSY(BUSY), .DONE(DONE), .BURST_CNT(BURST_CNT), .LOST_CNT(LOST_CNT)
    );

    typedef struct packed {
        logic        start, abort, full;
        logic [6:0]  nsamp;
        logic [1:0]  mode;
        logic        e_wren, e_busy, e_done;
        logic [11:0] e_wdata;
        logic [7:0]  e_lost;
    } vec_t;

    vec_t tbl [0:18];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_word(input int mode, input int idx);
        int strip, chan, samp;
        case (mode)
            0: return 12'(idx % 4096);
            1: begin
                strip = idx % NSTRIP;
                chan  = (idx / NSTRIP) % NCHAN;
                samp  = idx / WPS;
                return 12'((chan % 8) * 512 + (samp % 32) * 16 + strip);
            end
            2: return 12'(1 << (idx % DWIDTH));
            default: return (idx < 1024) ? prbs[idx][11:0] : 12'h0;
        endcase
    endfunction

    // Starts a burst from IDLE, checks every word, DONE, counters and the gap.
    task automatic run_burst(input int mode, input int nsamp, input int full_pct,
                             input int stall_at, input int stall_len, input bit poke_start);
        int L, idx, budget, stall_left;
        bit poked;
        L = nsamp * WPS; idx = 0; budget = 4 * L + 64; stall_left = stall_len; poked = 0;
        START = 1'b1; MODE = 2'(mode); NSAMP = 7'(nsamp); FULL = 1'b0;
        #1;
        chk("start_from_idle_busy", 32'(BUSY), 32'd0);
        cyc();
        START = 1'b0; MODE = 2'($urandom); NSAMP = 7'($urandom);
        while (idx < L && budget > 0) begin
            START = 1'b0;
            if (poke_start && !poked && idx == 3) begin
                START = 1'b1; poked = 1;
                if (exp_lost < 255) exp_lost++;
            end
            if (idx == stall_at && stall_left > 0) begin
                FULL = 1'b1; stall_left--;
            end else begin
                FULL = ($urandom_range(99) < full_pct);
            end
            #1;
            chk("burst_busy", 32'(BUSY), 32'd1);
            chk("burst_done_low", 32'(DONE), 32'd0);
            chk("wdata", 32'(WDATA), 32'(model_word(mode, idx)));
            if (mode == 3 && idx == 0) chk("prbs_first", 32'(WDATA), 32'h0CE1);
            if (FULL) chk("wren_full", 32'(WREN), 32'd0);
            else      chk("wren", 32'(WREN), 32'd1);
            if (!FULL) idx++;
            cyc();
            budget--;
        end
        START = 1'b0; FULL = 1'b0;
        if (idx < L) chk("burst_timeout", 32'(idx), 32'(L));
        #1;
        exp_bursts++;
        chk("done", 32'(DONE), 32'd1);
        chk("done_wren", 32'(WREN), 32'd0);
        chk("burst_cnt", 32'(BURST_CNT), 32'(exp_bursts));
        chk("lost_cnt", 32'(LOST_CNT), 32'(exp_lost));
        chk("gap_busy_first", 32'(BUSY), 32'd1);
        for (int g = 1; g < GAP_CYC; g++) begin
            cyc(); #1;
            chk("gap_busy", 32'(BUSY), 32'd1);
            chk("gap_wren", 32'(WREN), 32'd0);
            chk("gap_done", 32'(DONE), 32'd0);
        end
        cyc(); #1;
        chk("idle_after_gap", 32'(BUSY), 32'd0);
        cyc();
    endtask

    initial begin
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < 1024; i++) begin
            prbs[i] = s;
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end

        // {start, abort, full, nsamp, mode, e_wren, e_busy, e_done, e_wdata, e_lost}
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 7'd1, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 7'd1, 2'd1, 1'b0, 1'b0, 1'b0, 12'h000, 8'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 7'd0, 2'd2, 1'b1, 1'b1, 1'b0, 12'h000, 8'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 7'd0, 2'd2, 1'b1, 1'b1, 1'b0, 12'h001, 8'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 7'd0, 2'd2, 1'b0, 1'b1, 1'b0, 12'h002, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 7'd0, 2'd2, 1'b1, 1'b1, 1'b0, 12'h002, 8'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 7'd0, 2'd2, 1'b1, 1'b1, 1'b0, 12'h003, 8'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 7'd0, 2'd2, 1'b0, 1'b0, 1'b0, 12'h004, 8'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 7'd0, 2'd2, 1'b0, 1'b0, 1'b0, 12'h000, 8'd2};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 7'd1, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'd2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 7'd1, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'd2};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 7'd1, 2'd2, 1'b0, 1'b0, 1'b0, 12'h000, 8'd2};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 7'd1, 2'd3, 1'b1, 1'b1, 1'b0, 12'h001, 8'd2};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 7'd1, 2'd3, 1'b1, 1'b1, 1'b0, 12'h002, 8'd2};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 7'd1, 2'd3, 1'b1, 1'b1, 1'b0, 12'h004, 8'd2};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 7'd1, 2'd3, 1'b0, 1'b0, 1'b0, 12'h008, 8'd2};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 7'd1, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000, 8'd2};

        // Reset: START during reset must be ignored.
        RST = 1'b1; START = 1'b1;
        cyc(); #1;
        chk("rst_wren", 32'(WREN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        cyc();
        RST = 1'b0; START = 1'b0;
        #1;
        chk("reset_wdata", 32'(WDATA), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_burst_cnt", 32'(BURST_CNT), 32'd0);
        chk("reset_lost_cnt", 32'(LOST_CNT), 32'd0);
        cyc();

        for (int i = 0; i < 19; i++) begin
            START = tbl[i].start; ABORT = tbl[i].abort; FULL = tbl[i].full;
            NSAMP = tbl[i].nsamp; MODE = tbl[i].mode;
            #1;
            chk($sformatf("tbl%0d_wren", i), 32'(WREN), 32'(tbl[i].e_wren));
            chk($sformatf("tbl%0d_busy", i), 32'(BUSY), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), 32'(DONE), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_wdata", i), 32'(WDATA), 32'(tbl[i].e_wdata));
            chk($sformatf("tbl%0d_lost", i), 32'(LOST_CNT), 32'(tbl[i].e_lost));
            cyc();
        end
        START = 1'b0; ABORT = 1'b0; FULL = 1'b0;
        exp_lost = 2;

        // Full default burst, then a stalled burst, then two PRBS bursts.
        run_burst(0, 8, 0, -1, 0, 1'b0);
        run_burst(0, 1, 0, 5, 10, 1'b0);
        run_burst(3, 1, 0, -1, 0, 1'b0);
        run_burst(3, 1, 0, -1, 0, 1'b0);

        // Abort at word 50, then a clean restart from word 0.
        START = 1'b1; MODE = 2'd0; NSAMP = 7'd1;
        cyc();
        START = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("pre_abort_wren", 32'(WREN), 32'd1);
            chk("pre_abort_wdata", 32'(WDATA), 32'(i));
            cyc();
        end
        ABORT = 1'b1;
        #1;
        chk("abort_wdata", 32'(WDATA), 32'd50);
        chk("abort_wren", 32'(WREN), 32'd0);
        cyc();
        ABORT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_abort_wren", 32'(WREN), 32'd0);
            chk("post_abort_busy", 32'(BUSY), 32'd0);
            chk("post_abort_done", 32'(DONE), 32'd0);
            chk("post_abort_burst_cnt", 32'(BURST_CNT), 32'(exp_bursts));
            cyc();
        end
        run_burst(0, 1, 0, -1, 0, 1'b0);

        // Continuous mode: back-to-back bursts separated by exactly GAP_CYC idle cycles.
        CONT = 1'b1; START = 1'b1; MODE = 2'd0; NSAMP = 7'd1;
        cyc();
        START = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < WPS; i++) begin
                #1;
                chk("cont_wren", 32'(WREN), 32'd1);
                chk("cont_wdata", 32'(WDATA), 32'(i));
                cyc();
            end
            for (int g = 0; g < GAP_CYC; g++) begin
                #1;
                chk("cont_gap_wren", 32'(WREN), 32'd0);
                chk("cont_gap_busy", 32'(BUSY), 32'd1);
                if (g == 0) begin
                    exp_bursts++;
                    chk("cont_done", 32'(DONE), 32'd1);
                    chk("cont_burst_cnt", 32'(BURST_CNT), 32'(exp_bursts));
                end
                cyc();
            end
        end
        #1;
        chk("cont_restart_wren", 32'(WREN), 32'd1);
        chk("cont_restart_wdata", 32'(WDATA), 32'd0);
        CONT = 1'b0; ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        #1;
        chk("cont_stop_busy", 32'(BUSY), 32'd0);
        cyc();

        // Randomized bursts with back-pressure and stray START pulses.
        for (int r = 0; r < 6; r++)
            run_burst(int'($urandom_range(3)), int'($urandom_range(2, 1)), 30, -1, 0, r[0]);

        // Reset in the middle of a burst discards it silently.
        START = 1'b1; MODE = 2'd0; NSAMP = 7'd1;
        cyc();
        START = 1'b0;
        cyc(); cyc(); cyc();
        RST = 1'b1;
        #1;
        chk("midrst_wren", 32'(WREN), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        cyc();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("after_rst_busy", 32'(BUSY), 32'd0);
            chk("after_rst_done", 32'(DONE), 32'd0);
            chk("after_rst_wdata", 32'(WDATA), 32'd0);
            chk("after_rst_burst_cnt", 32'(BURST_CNT), 32'd0);
            chk("after_rst_lost_cnt", 32'(LOST_CNT), 32'd0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
